// File: rtl/twitchcore_pkg.sv
// Shared types and constants for the twitchcore boot loader.
//   boot_state_t   : loader FSM state encoding
//   BYTES_PER_WORD : bytes assembled into one little-endian RAM word
package twitchcore_pkg;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    LOAD = 3'd1,
    CSUM = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } boot_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/twitchcore_word_packer.sv
// Little-endian byte-to-word assembler.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   take       : a byte is accepted this cycle
//   byte_in    : the accepted byte
//   word       : assembled word, meaningful only while word_valid is high
//   word_valid : one-cycle pulse on the cycle the 4th byte is accepted
module twitchcore_word_packer
  import twitchcore_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        take,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  idx;
  logic [23:0] low_bytes;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= 2'd0;
    end else if (take) begin
      idx <= idx + 2'd1;
    end
  end

  // Byte lanes 0..2 are data only; the byte index alone defines framing.
  always_ff @(posedge clk) begin
    if (take) begin
      case (idx)
        2'd0:    low_bytes[7:0]   <= byte_in;
        2'd1:    low_bytes[15:8]  <= byte_in;
        2'd2:    low_bytes[23:16] <= byte_in;
        default: low_bytes        <= low_bytes;
      endcase
    end
  end

  // The 4th byte completes the word combinationally so the write can be
  // registered exactly one cycle after it is accepted.
  assign word       = {byte_in, low_bytes};
  assign word_valid = take && (idx == LAST_IDX);

endmodule

// File: rtl/twitchcore_boot_loader.sv
// Streams a firmware image (LE word count N, N LE data words, LE XOR checksum)
// into the core's word RAM while holding the core in reset. The core is
// released only after the trailer matches the XOR of header and data words.
// Ports:
//   clk, reset    : clock and asynchronous active-high reset
//   s_valid/s_data/s_ready : byte stream in, accepted when s_valid && s_ready
//   mem_we/mem_addr/mem_wdata : one-cycle RAM word write
//   core_resetn   : active-low reset to twitchcore
//   done          : image loaded and verified, core running
//   error         : sticky length or checksum fault
//   words_loaded  : number of data words written
module twitchcore_boot_loader
  import twitchcore_pkg::*;
#(
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = (2 ** ADDR_W) - int'(BASE_ADDR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_resetn,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [32:0]     MAX_WORDS_EXT = 33'(MAX_WORDS);
  localparam logic [ADDR_W:0] ONE_WORD      = (ADDR_W + 1)'(1);

  boot_state_t     state;
  boot_state_t     state_next;
  logic            take;
  logic [31:0]     word;
  logic            word_valid;
  logic [31:0]     csum;
  logic [ADDR_W:0] n_words;
  logic            load_word;

  assign take      = s_valid && s_ready;
  assign load_word = (state == LOAD) && word_valid;

  twitchcore_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .take       (take),
    .byte_in    (s_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_next = state;
    case (state)
      HDR: begin
        if (word_valid) begin
          if ({1'b0, word} > MAX_WORDS_EXT) begin
            state_next = ERR;
          end else if (word == 32'd0) begin
            state_next = CSUM;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (word_valid && ((words_loaded + ONE_WORD) == n_words)) begin
          state_next = CSUM;
        end
      end
      CSUM: begin
        if (word_valid) begin
          state_next = (word == csum) ? RUN : ERR;
        end
      end
      default: state_next = state;
    endcase
  end

  // Control: FSM, ready and status flags are registered from the next state
  // so s_ready drops the cycle after the final byte and is low during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HDR;
      s_ready     <= 1'b0;
      core_resetn <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_next;
      s_ready     <= (state_next == HDR) || (state_next == LOAD) ||
                     (state_next == CSUM);
      core_resetn <= (state_next == RUN);
      done        <= (state_next == RUN);
      error       <= (state_next == ERR);
    end
  end

  // Write port, counters and checksum: one write the cycle after each data
  // word completes; address and data hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= 32'd0;
      words_loaded <= '0;
      csum         <= 32'd0;
      n_words      <= '0;
    end else begin
      mem_we <= load_word;
      if ((state == HDR) && word_valid) begin
        csum    <= word;
        n_words <= word[ADDR_W:0];
      end
      if (load_word) begin
        mem_addr     <= BASE_ADDR + words_loaded[ADDR_W-1:0];
        mem_wdata    <= word;
        words_loaded <= words_loaded + ONE_WORD;
        csum         <= csum ^ word;
      end
    end
  end

endmodule

// File: tb/tb_twitchcore_boot_loader.sv
module tb_twitchcore_boot_loader;

  localparam int ADDR_W = 14;
  localparam logic [31:0] W0       = 32'h0000_0013;
  localparam logic [31:0] W1       = 32'hDEAD_BEEF;
  localparam logic [31:0] GOOD_SUM = 32'hDEAD_BEFE;  // 2 ^ 0x13 ^ 0xDEADBEEF
  localparam logic [31:0] TOO_LONG = 32'd16385;      // MAX_WORDS + 1

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'd0;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_resetn;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int errors = 0;

  // Monitor state: accepted-byte cycles and observed writes since last reset.
  int          cyc = 0;
  int          acc_cyc[$];
  int          we_cyc[$];
  logic [31:0] we_addr[$];
  logic [31:0] we_data[$];

  twitchcore_boot_loader dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_resetn  (core_resetn),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      cyc = 0;
      acc_cyc.delete();
      we_cyc.delete();
      we_addr.delete();
      we_data.delete();
    end else begin
      cyc = cyc + 1;
      if (s_valid && s_ready) acc_cyc.push_back(cyc);
      if (mem_we) begin
        we_cyc.push_back(cyc);
        we_addr.push_back(32'(mem_addr));
        we_data.push_back(mem_wdata);
      end
    end
  end

  task automatic do_reset();
    s_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    if (gaps) begin
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(0, 1) == 0) break;
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b1;
    s_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    s_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL byte_accept_timeout: byte %h not accepted, required acceptance within 20 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    logic [31:0] tmp;
    tmp = w;
    for (int i = 0; i < 4; i++) send_byte(tmp[8*i +: 8], gaps);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    s_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s_ready, mem_we, core_resetn, done, error} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: ready/we/resetn/done/error=%b required 00000",
               {s_ready, mem_we, core_resetn, done, error});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== 32'd0 || words_loaded !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h words=%0d required 0 0 0",
               mem_addr, mem_wdata, words_loaded);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: s_ready=%b required 1", s_ready);
    end
  endtask

  task automatic check_good_result(input string tag);
    checks++;
    if (we_addr.size() !== 2) begin
      errors++;
      $display("FAIL %s_write_count: %0d required 2", tag, we_addr.size());
    end else begin
      checks++;
      if (we_addr[0] !== 32'd0 || we_data[0] !== W0) begin
        errors++;
        $display("FAIL %s_write0: addr=%h data=%h required 0 %h", tag, we_addr[0], we_data[0], W0);
      end
      checks++;
      if (we_addr[1] !== 32'd1 || we_data[1] !== W1) begin
        errors++;
        $display("FAIL %s_write1: addr=%h data=%h required 1 %h", tag, we_addr[1], we_data[1], W1);
      end
      checks++;
      if (acc_cyc.size() < 12 || we_cyc[0] !== acc_cyc[7] + 1 || we_cyc[1] !== acc_cyc[11] + 1) begin
        errors++;
        $display("FAIL %s_write_latency: we cycles %0d %0d required one after 4th-byte accepts",
                 tag, we_cyc[0], we_cyc[1]);
      end
    end
  endtask

  task automatic test_good_image(input bit gaps, input string tag);
    do_reset();
    send_word(32'd2, gaps);
    send_word(W0, gaps);
    send_word(W1, gaps);
    send_word(GOOD_SUM, gaps);
    checks++;
    if (done !== 1'b1 || core_resetn !== 1'b1 || error !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_run: done=%b resetn=%b error=%b ready=%b required 1 1 0 0",
               tag, done, core_resetn, error, s_ready);
    end
    idle(3);
    check_good_result(tag);
    checks++;
    if (words_loaded !== 15'd2) begin
      errors++;
      $display("FAIL %s_words_loaded: %0d required 2", tag, words_loaded);
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    send_word(32'd2, 1'b0);
    send_word(W0, 1'b0);
    send_word(W1, 1'b0);
    send_word(GOOD_SUM ^ 32'd1, 1'b0);
    idle(4);
    checks++;
    if (error !== 1'b1 || core_resetn !== 1'b0 || done !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL badsum_status: error=%b resetn=%b done=%b ready=%b required 1 0 0 0",
               error, core_resetn, done, s_ready);
    end
    check_good_result("badsum");
  endtask

  task automatic test_zero_length();
    do_reset();
    send_word(32'd0, 1'b0);
    send_word(32'd0, 1'b0);
    checks++;
    if (done !== 1'b1 || core_resetn !== 1'b1 || acc_cyc.size() !== 8) begin
      errors++;
      $display("FAIL zero_run: done=%b resetn=%b accepted=%0d required 1 1 8",
               done, core_resetn, acc_cyc.size());
    end
    idle(3);
    checks++;
    if (we_addr.size() !== 0 || words_loaded !== '0) begin
      errors++;
      $display("FAIL zero_writes: writes=%0d words=%0d required 0 0", we_addr.size(), words_loaded);
    end
  endtask

  task automatic test_too_long();
    do_reset();
    send_word(TOO_LONG, 1'b0);
    checks++;
    if (error !== 1'b1 || s_ready !== 1'b0 || core_resetn !== 1'b0) begin
      errors++;
      $display("FAIL too_long_err: error=%b ready=%b resetn=%b required 1 0 0",
               error, s_ready, core_resetn);
    end
    s_valid = 1'b1;
    s_data  = 8'hAA;
    idle(6);
    s_valid = 1'b0;
    checks++;
    if (we_addr.size() !== 0 || acc_cyc.size() !== 4 || error !== 1'b1) begin
      errors++;
      $display("FAIL too_long_ignore: writes=%0d accepted=%0d error=%b required 0 4 1",
               we_addr.size(), acc_cyc.size(), error);
    end
  endtask

  task automatic test_abort_reload();
    logic [31:0] w1;
    w1 = W1;
    do_reset();
    send_word(32'd2, 1'b0);
    send_word(W0, 1'b0);
    send_byte(w1[7:0], 1'b0);
    @(posedge clk); #1;
    checks++;
    if (mem_wdata !== W0 || words_loaded !== 15'd1) begin
      errors++;
      $display("FAIL abort_pre: wdata=%h words=%0d required %h 1", mem_wdata, words_loaded, W0);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0 || mem_wdata !== 32'd0 || words_loaded !== '0 ||
        mem_addr !== '0 || done !== 1'b0 || error !== 1'b0 || core_resetn !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: ready=%b wdata=%h words=%0d addr=%h done=%b error=%b resetn=%b required all 0",
               s_ready, mem_wdata, words_loaded, mem_addr, done, error, core_resetn);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    send_word(32'd2, 1'b0);
    send_word(W0, 1'b0);
    send_word(W1, 1'b0);
    send_word(GOOD_SUM, 1'b0);
    idle(2);
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL abort_reload_run: done=%b error=%b required 1 0", done, error);
    end
    check_good_result("reload");
  endtask

  initial begin
    test_reset();
    test_good_image(1'b0, "good");
    test_bad_checksum();
    test_zero_length();
    test_too_long();
    test_good_image(1'b1, "gaps");
    test_abort_reload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
